// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and character helpers for the HD44780 phrase writer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_LINE1     = 8'h80;
  localparam logic [7:0] LCD_LINE2     = 8'hC0;

  localparam int LCD_COLS  = 16;
  localparam int LCD_CHARS = 32;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_TILDE = 8'h7E;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SET_LINE,
    ST_FETCH,
    ST_LATCH,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_PULSE,
    BUS_WAIT
  } bus_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] n);
    case (n)
      2'd0:    return LCD_FUNC_8B2L;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY_INC;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // Anything the panel cannot render as a glyph (controls, DEL, high codes) shows as a blank.
  function automatic logic [7:0] printable(input logic [7:0] c);
    return (c >= CHAR_SPACE && c <= CHAR_TILDE) ? c : CHAR_SPACE;
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 bus write: setup cycle, E strobe, then a post-strobe wait ending in a one-cycle ack.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       longWait,
  output logic       ack,
  output logic       lcdE,
  output logic       lcdRs,
  output logic [7:0] lcdData
);

  localparam int MAX_WAIT = (CLEAR_WAIT_CYCLES > CMD_WAIT_CYCLES) ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_CNT  = (MAX_WAIT > E_PULSE_CYCLES) ? MAX_WAIT : E_PULSE_CYCLES;
  localparam int CNT_W    = $clog2(MAX_CNT + 1);

  bus_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       data_q, data_next;
  logic             rs_q, rs_next;
  logic             long_q, long_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= BUS_IDLE;
      cnt    <= '0;
      data_q <= '0;
      rs_q   <= 1'b0;
      long_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      data_q <= data_next;
      rs_q   <= rs_next;
      long_q <= long_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    data_next  = data_q;
    rs_next    = rs_q;
    long_next  = long_q;
    ack        = 1'b0;
    unique case (state)
      BUS_IDLE: begin
        if (req) begin
          data_next  = data;
          rs_next    = rs;
          long_next  = longWait;
          state_next = BUS_SETUP;
        end
      end
      BUS_SETUP: begin
        cnt_next   = CNT_W'(E_PULSE_CYCLES - 1);
        state_next = BUS_PULSE;
      end
      BUS_PULSE: begin
        if (cnt == '0) begin
          cnt_next   = long_q ? CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);
          state_next = BUS_WAIT;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      BUS_WAIT: begin
        if (cnt == '0) begin
          ack        = 1'b1;
          state_next = BUS_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = BUS_IDLE;
    endcase
  end

  // Data and RS only move in BUS_IDLE, so they are stable for the whole strobe.
  assign lcdE    = (state == BUS_PULSE);
  assign lcdRs   = rs_q;
  assign lcdData = data_q;

endmodule

// File: rtl/lcd_phrase_writer.sv
// Runs the HD44780 power-up init once, then writes a 32-char ROM phrase (two 16-char lines) per start pulse.
module lcd_phrase_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_WAIT_CYCLES = 750000,
  parameter int E_PULSE_CYCLES      = 25,
  parameter int CMD_WAIT_CYCLES     = 2000,
  parameter int CLEAR_WAIT_CYCLES   = 82000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] romAddr,
  input  logic [7:0] romData,
  output logic [7:0] lcdData,
  output logic       lcdRs,
  output logic       lcdRw,
  output logic       lcdE,
  output logic       busy,
  output logic       done
);

  localparam int         PWR_W       = $clog2(POWERUP_WAIT_CYCLES + 1);
  localparam logic [4:0] LINE1_LAST  = 5'(LCD_COLS - 1);
  localparam logic [4:0] LINE2_FIRST = 5'(LCD_COLS);
  localparam logic [4:0] LAST_IDX    = 5'(LCD_CHARS - 1);

  state_t           state, state_next;
  logic [PWR_W-1:0] pwr_cnt, pwr_next;
  logic [1:0]       init_idx, init_next;
  logic [4:0]       idx, idx_next;
  logic [7:0]       char_q, char_next;
  logic             req_sent, sent_next;
  logic [4:0]       rom_addr_q;

  logic       req, req_rs, req_long, ack;
  logic [7:0] req_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_PWR_WAIT;
      pwr_cnt    <= '0;
      init_idx   <= '0;
      idx        <= '0;
      char_q     <= '0;
      req_sent   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state    <= state_next;
      pwr_cnt  <= pwr_next;
      init_idx <= init_next;
      idx      <= idx_next;
      char_q   <= char_next;
      req_sent <= sent_next;
      // Address is presented for the whole FETCH cycle so romData is ready in LATCH.
      if (state_next == ST_FETCH) rom_addr_q <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    pwr_next   = pwr_cnt;
    init_next  = init_idx;
    idx_next   = idx;
    char_next  = char_q;
    sent_next  = req_sent;
    req        = 1'b0;
    req_rs     = 1'b0;
    req_data   = 8'h00;
    req_long   = 1'b0;
    unique case (state)
      ST_PWR_WAIT: begin
        if (pwr_cnt == PWR_W'(POWERUP_WAIT_CYCLES - 1)) state_next = ST_INIT;
        else pwr_next = pwr_cnt + 1'b1;
      end
      ST_INIT: begin
        req_data  = init_cmd(init_idx);
        req_long  = (req_data == LCD_CLEAR);
        req       = !req_sent;
        sent_next = 1'b1;
        if (ack) begin
          sent_next = 1'b0;
          if (init_idx == 2'd3) state_next = ST_IDLE;
          else init_next = init_idx + 1'b1;
        end
      end
      ST_IDLE: begin
        if (start) begin
          idx_next   = '0;
          state_next = ST_SET_LINE;
        end
      end
      ST_SET_LINE: begin
        req_data  = idx[4] ? LCD_LINE2 : LCD_LINE1;
        req       = !req_sent;
        sent_next = 1'b1;
        if (ack) begin
          sent_next  = 1'b0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: begin
        char_next  = romData;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        req_rs    = 1'b1;
        req_data  = printable(char_q);
        req       = !req_sent;
        sent_next = 1'b1;
        if (ack) begin
          sent_next = 1'b0;
          if (idx == LINE1_LAST) begin
            idx_next   = LINE2_FIRST;
            state_next = ST_SET_LINE;
          end else if (idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_PWR_WAIT;
    endcase
  end

  lcd_bus_cycle #(
    .E_PULSE_CYCLES   (E_PULSE_CYCLES),
    .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_bus (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .rs      (req_rs),
    .data    (req_data),
    .longWait(req_long),
    .ack     (ack),
    .lcdE    (lcdE),
    .lcdRs   (lcdRs),
    .lcdData (lcdData)
  );

  assign romAddr = rom_addr_q;
  assign lcdRw   = 1'b0;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_lcd_phrase_writer.sv
// Bench for lcd_phrase_writer: a queue of expected LCD writes built from the ROM contents plus a bus-protocol monitor.
module tb_lcd_phrase_writer;

  localparam int PWR = 20;
  localparam int EP  = 2;
  localparam int CW  = 4;
  localparam int CLW = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] romAddr;
  logic [7:0] romData;
  logic [7:0] lcdData;
  logic       lcdRs, lcdRw, lcdE, busy, done;

  logic [7:0] rom [32];
  logic [8:0] exp_q [$];
  logic [8:0] exp_w;

  int vectors     = 0;
  int miscompares = 0;
  int done_pulses = 0;
  int writes_seen = 0;

  int         since_rst, e_width, low_cnt;
  logic       prev_e, prev_rs, first_rise, last_long;
  logic [7:0] prev_data;

  lcd_phrase_writer #(
    .POWERUP_WAIT_CYCLES(PWR),
    .E_PULSE_CYCLES     (EP),
    .CMD_WAIT_CYCLES    (CW),
    .CLEAR_WAIT_CYCLES  (CLW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .romAddr(romAddr),
    .romData(romData),
    .lcdData(lcdData),
    .lcdRs  (lcdRs),
    .lcdRw  (lcdRw),
    .lcdE   (lcdE),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) romData <= rom[romAddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic check_min(input string name, input int act, input int min);
    vectors++;
    if (act < min) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [7:0] shown(input logic [7:0] c);
    return (c < 8'h20 || c > 8'h7e) ? 8'h20 : c;
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_pass();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, shown(rom[i])});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, shown(rom[i])});
  endtask

  task automatic load_hello();
    string l1, l2;
    l1 = "HELLO WORLD     ";
    l2 = "LT39A PROJETO 01";
    for (int i = 0; i < 16; i++) begin
      rom[i]      = l1[i];
      rom[16 + i] = l2[i];
    end
  endtask

  task automatic load_zero();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
  endtask

  task automatic load_mixed();
    for (int i = 0; i < 32; i++) rom[i] = 8'(i * 9 + 3);
    rom[0] = 8'h7F;
    rom[1] = 8'h0A;
    rom[2] = 8'h7E;
    rom[3] = 8'h20;
    rom[4] = 8'h1F;
    rom[5] = 8'h80;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_romAddr", romAddr, 0);
    check("rst_lcdData", lcdData, 0);
    check("rst_lcdRs", lcdRs, 0);
    check("rst_lcdRw", lcdRw, 0);
    check("rst_lcdE", lcdE, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
  endtask

  task automatic wait_idle(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (!busy) seen = 1'b1;
    end
    if (!seen) fail("idle_timeout");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      fail("done_timeout");
    end else begin
      check("busy_in_done", busy, 1);
      if (poke) start = 1'b1;
      tick(1);
      start = 1'b0;
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
    end
  endtask

  // Bus monitor: pops one expected write per E rise and checks strobe protocol every cycle.
  always @(negedge clock) begin
    if (reset) begin
      prev_e     = 1'b0;
      e_width    = 0;
      low_cnt    = 0;
      since_rst  = 0;
      first_rise = 1'b1;
      last_long  = 1'b0;
      prev_rs    = lcdRs;
      prev_data  = lcdData;
    end else begin
      since_rst++;
      check("lcdRw_low", lcdRw, 0);
      if (done) done_pulses++;
      if (lcdE && !prev_e) begin
        writes_seen++;
        check("setup_before_rise", {lcdRs, lcdData}, {prev_rs, prev_data});
        if (first_rise) check_min("powerup_wait", since_rst, PWR);
        else check_min("write_gap", low_cnt, last_long ? CLW + 1 : CW + 1);
        first_rise = 1'b0;
        if (exp_q.size() == 0) begin
          fail("spurious_write");
        end else begin
          exp_w = exp_q.pop_front();
          check("write", {lcdRs, lcdData}, exp_w);
        end
        e_width = 1;
      end else if (lcdE) begin
        check("hold_while_e", {lcdRs, lcdData}, {prev_rs, prev_data});
        e_width++;
      end else if (prev_e) begin
        check("e_width", e_width, EP);
        low_cnt   = 1;
        last_long = (!prev_rs && prev_data == 8'h01);
      end else begin
        low_cnt++;
      end
      prev_e    = lcdE;
      prev_rs   = lcdRs;
      prev_data = lcdData;
    end
  end

  initial begin
    int ws0;
    bit hit;
    reset = 1'b1;
    start = 1'b0;
    load_zero();

    // Reset values and power-up init
    tick(3);
    check_reset_values();
    push_init();
    reset = 1'b0;
    wait_idle(500);
    check("init_writes_left", exp_q.size(), 0);
    check("init_write_count", writes_seen, 4);
    check("no_done_in_init", done_pulses, 0);

    // Normal phrase
    load_hello();
    push_pass();
    check("pin_len", exp_q.size(), 34);
    check("pin_line1_cmd", exp_q[0], 9'h080);
    check("pin_H", exp_q[1], 9'h148);
    check("pin_space", exp_q[12], 9'h120);
    check("pin_line2_cmd", exp_q[17], 9'h0C0);
    check("pin_last", exp_q[33], 9'h131);
    pulse_start();
    wait_done(2000, 1'b0);
    check("pass1_left", exp_q.size(), 0);
    check("pass1_done", done_pulses, 1);
    check("pass1_writes", writes_seen, 38);

    // Empty ROM and out-of-range characters
    load_zero();
    push_pass();
    check("pin_zero", exp_q[5], 9'h120);
    pulse_start();
    wait_done(2000, 1'b0);
    check("zero_left", exp_q.size(), 0);

    load_mixed();
    push_pass();
    check("pin_7f", exp_q[1], 9'h120);
    check("pin_0a", exp_q[2], 9'h120);
    check("pin_7e", exp_q[3], 9'h17E);
    check("pin_1f", exp_q[5], 9'h120);
    check("pin_80", exp_q[6], 9'h120);
    pulse_start();
    wait_done(2000, 1'b0);
    check("mixed_left", exp_q.size(), 0);

    // Start held through a pass, and a start landing on the DONE cycle
    load_hello();
    push_pass();
    start = 1'b1;
    tick(100);
    start = 1'b0;
    wait_done(2000, 1'b1);
    tick(60);
    check("held_start_left", exp_q.size(), 0);
    check("held_start_idle", busy, 0);
    check("held_start_done", done_pulses, 4);

    // Reset in the middle of a data strobe
    push_pass();
    ws0 = writes_seen;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick(1);
      if (lcdE && lcdRs && writes_seen >= ws0 + 6) hit = 1'b1;
    end
    if (!hit) fail("midpass_timeout");
    reset = 1'b1;
    exp_q.delete();
    push_init();
    tick(1);
    check("e_drops_on_reset", lcdE, 0);
    tick(2);
    check_reset_values();
    reset = 1'b0;
    wait_idle(500);
    check("reinit_left", exp_q.size(), 0);

    load_mixed();
    push_pass();
    pulse_start();
    wait_done(2000, 1'b0);
    tick(20);
    check("final_left", exp_q.size(), 0);
    check("final_done", done_pulses, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
